uart_tx_fifo: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8-bit single-buffer transmitter in the peripheral subsystem.
- Adds a write FIFO and an internal baud divider.
- Data width is a parameter; parity mode and stop-bit count are selected at run time.
- Sits behind the UART register block: the bus side writes bytes into the FIFO, and the block serialises them onto txd.

---
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO and baud divider; optional line break via UART_TX_BREAK_EN.
// Latency: txd falls one cycle after a write to an empty FIFO; writes while full are dropped and flagged by wr_ovf.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  par_mode,
  input  logic                        stop2,
  input  logic                        wr,
  input  logic [DATA_BITS-1:0]        wdat,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        wr_ovf,
  output logic                        busy,
  output logic                        tint,
`ifdef UART_TX_BREAK_EN
  input  logic                        brk,
`endif
  output logic                        txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [DIV_W-1:0]     cnt, div_l;
  logic [DATA_BITS-1:0] sr;
  logic [3:0]           bitn;
  logic                 par_en, par_bit, stop2_l, stopn, brk_hold, brk_on;
  logic                 push, launch, bit_end, last_stop;

`ifdef UART_TX_BREAK_EN
  assign brk_on = brk;
`else
  assign brk_on = 1'b0;
`endif

  assign full      = level == LW'(FIFO_DEPTH);
  assign empty     = level == '0;
  assign push      = wr && !full;
  assign bit_end   = cnt == div_l;
  assign last_stop = !stop2_l || stopn;
  // A frame may start from IDLE or straight out of the final stop bit (back-to-back).
  assign launch    = en && !empty && !brk_on && !brk_hold &&
                     (state == IDLE || (state == STOP && bit_end && last_stop));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      wr_ovf <= 1'b0;
    end else begin
      wr_ovf <= wr && full;
      if (push)   wptr <= wptr + 1'b1;
      if (launch) rptr <= rptr + 1'b1;
      if (push && !launch)      level <= level + 1'b1;
      else if (!push && launch) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_l    <= '0;
      sr       <= '0;
      bitn     <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2_l  <= 1'b0;
      stopn    <= 1'b0;
      brk_hold <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      tint     <= 1'b0;
    end else begin
      tint <= state == STOP && bit_end && last_stop;
      if (launch) begin
        state   <= START;
        sr      <= mem[rptr];
        div_l   <= baud_div;
        par_en  <= par_mode == 2'b01 || par_mode == 2'b10;
        par_bit <= (^mem[rptr]) ^ (par_mode == 2'b10);
        stop2_l <= stop2;
        stopn   <= 1'b0;
        bitn    <= '0;
        cnt     <= '0;
        txd     <= 1'b0;
        busy    <= 1'b1;
      end else if (state == IDLE) begin
        // cnt doubles as the post-break mark timer while idle.
        if (brk_on) begin
          txd      <= 1'b0;
          brk_hold <= 1'b1;
          cnt      <= '0;
        end else begin
          txd <= 1'b1;
          if (brk_hold) begin
            if (cnt == baud_div) begin
              brk_hold <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      end else if (!bit_end) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        case (state)
          START: begin
            state <= DATA;
            txd   <= sr[0];
            sr    <= sr >> 1;
          end
          DATA: begin
            if (bitn == 4'(DATA_BITS - 1)) begin
              state <= par_en ? PARITY : STOP;
              txd   <= par_en ? par_bit : 1'b1;
            end else begin
              bitn <= bitn + 1'b1;
              txd  <= sr[0];
              sr   <= sr >> 1;
            end
          end
          PARITY: begin
            state <= STOP;
            txd   <= 1'b1;
          end
          STOP: begin
            if (!last_stop) begin
              stopn <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame vector table plus hand-written FIFO, baud, reset and break sequences.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n, en, stop2, wr;
  logic [15:0] baud_div;
  logic [1:0]  par_mode;
  logic [7:0]  wdat;
  logic        full, empty, wr_ovf, busy, tint, txd;
  logic [3:0]  level;
`ifdef UART_TX_BREAK_EN
  logic        brk;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk(clk), .rst_n(rst_n), .en(en), .baud_div(baud_div), .par_mode(par_mode),
    .stop2(stop2), .wr(wr), .wdat(wdat), .full(full), .empty(empty), .level(level),
    .wr_ovf(wr_ovf), .busy(busy), .tint(tint),
`ifdef UART_TX_BREAK_EN
    .brk(brk),
`endif
    .txd(txd)
  );

  // seq holds the expected line bits in transmission order, first bit sent in the MSB of the nb-bit field.
  typedef struct {
    logic [7:0]  dat;
    logic [1:0]  pm;
    logic        s2;
    logic [15:0] div;
    int          nb;
    logic [11:0] seq;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return d[j-1];
  endfunction

  task automatic send_frame(input vec_t v, input string tag);
    int p, len;
    logic [11:0] cap;
    int bad;
    p = int'(v.div) + 1;
    len = p * v.nb;
    baud_div = v.div; par_mode = v.pm; stop2 = v.s2; en = 1'b1;
    wdat = v.dat; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    cap = '0; bad = 0;
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      if (c % p == 0) cap = {cap[10:0], txd};
      else if (txd !== cap[0]) bad++;
      if (tint !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk({tag, "_bits"}, cap, v.seq);
    chk({tag, "_steady"}, bad, 0);
    @(posedge clk); #1;
    chk({tag, "_tint"}, tint, 1);
    chk({tag, "_busy"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_tint_pulse"}, tint, 0);
  endtask

  initial begin
    int nbad, ntint, nbusy, hi;
    bit done;

    vecs[0] = '{dat: 8'hA5, pm: 2'b00, s2: 1'b0, div: 16'd3, nb: 10, seq: 12'b00_0101001011};
    vecs[1] = '{dat: 8'h03, pm: 2'b10, s2: 1'b1, div: 16'd3, nb: 12, seq: 12'b011000000111};
    vecs[2] = '{dat: 8'h03, pm: 2'b01, s2: 1'b1, div: 16'd3, nb: 12, seq: 12'b011000000011};
    vecs[3] = '{dat: 8'h00, pm: 2'b11, s2: 1'b0, div: 16'd0, nb: 10, seq: 12'b00_0000000001};
    vecs[4] = '{dat: 8'hFF, pm: 2'b01, s2: 1'b0, div: 16'd1, nb: 11, seq: 12'b0_01111111101};
    vecs[5] = '{dat: 8'h80, pm: 2'b10, s2: 1'b1, div: 16'd2, nb: 12, seq: 12'b000000001011};

    rst_n = 1'b0; en = 1'b0; stop2 = 1'b0; wr = 1'b0;
    baud_div = 16'd3; par_mode = 2'b00; wdat = 8'h00;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tint", tint, 0);
    chk("rst_wr_ovf", wr_ovf, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) send_frame(vecs[i], $sformatf("v%0d", i));

    // Fill the FIFO with the transmitter disabled, then overflow it.
    en = 1'b0; baud_div = 16'd0; par_mode = 2'b00; stop2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; wdat = 8'(8'h10 + i);
      @(posedge clk); #1;
    end
    chk("fill_level", level, 8);
    chk("fill_full", full, 1);
    chk("fill_ovf_quiet", wr_ovf, 0);
    wdat = 8'hEE;
    @(posedge clk); #1;
    wr = 1'b0;
    chk("ovf_pulse", wr_ovf, 1);
    chk("ovf_level", level, 8);
    @(posedge clk); #1;
    chk("ovf_pulse_end", wr_ovf, 0);

    en = 1'b1;
    nbad = 0; ntint = 0; nbusy = 0;
    for (int s = 0; s < 80; s++) begin
      @(posedge clk); #1;
      if (txd !== frame_bit(8'(8'h10 + s / 10), s % 10)) nbad++;
      if (tint === 1'b1) ntint++;
      if (busy !== 1'b1) nbusy++;
    end
    @(posedge clk); #1;
    if (tint === 1'b1) ntint++;
    chk("b2b_bits", nbad, 0);
    chk("b2b_tints", ntint, 8);
    chk("b2b_busy", nbusy, 0);
    chk("b2b_empty", empty, 1);
    chk("b2b_idle", busy, 0);
    nbad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (txd !== 1'b1 || busy !== 1'b0) nbad++;
    end
    chk("no_ninth_frame", nbad, 0);

    // Divisor change mid-frame applies from the next frame only.
    baud_div = 16'd3; wdat = 8'h5A; wr = 1'b1;
    @(posedge clk); #1;
    wdat = 8'hC3;
    nbad = 0;
    for (int s = 0; s < 60; s++) begin
      @(posedge clk); #1;
      if (s == 0) wr = 1'b0;
      if (s == 10) baud_div = 16'd1;
      if (s < 40) begin
        if (txd !== frame_bit(8'h5A, s / 4)) nbad++;
      end else begin
        if (txd !== frame_bit(8'hC3, (s - 40) / 2)) nbad++;
      end
      if (s == 40) chk("div_tint_mid", tint, 1);
    end
    chk("div_change_bits", nbad, 0);
    @(posedge clk); #1;
    chk("div_tint_end", tint, 1);
    baud_div = 16'd3;
    repeat (2) @(posedge clk);
    #1;

    // Reset during data bit 4 with three entries queued.
    wdat = 8'h00; wr = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    wr = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_rst_txd", txd, 0);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    #2 rst_n = 1'b1;
    nbad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (txd !== 1'b1 || busy !== 1'b0) nbad++;
    end
    chk("post_rst_quiet", nbad, 0);
    send_frame(vecs[0], "post_rst");

`ifdef UART_TX_BREAK_EN
    brk = 1'b1; baud_div = 16'd3; par_mode = 2'b00; stop2 = 1'b0;
    wdat = 8'h55; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    nbad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (txd !== 1'b0 || busy !== 1'b0) nbad++;
    end
    chk("brk_hold_low", nbad, 0);
    chk("brk_level", level, 1);
    brk = 1'b0;
    hi = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      if (txd === 1'b1) hi++;
      else done = 1'b1;
    end
    chk("brk_mark_cycles", hi, 4);
    chk("brk_start_busy", busy, 1);
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) done = 1'b1;
    end
    chk("brk_frame_done", done, 1);
    chk("brk_empty", empty, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
